// File: rtl/cci_mpf_prim_ram_rd_stream_if.sv
// Request, RAM-port and response signals for the block RAM read streamer.
// The streamer is the slave; the client driving requests and owning the RAM is the master.
interface cci_mpf_prim_ram_rd_stream_if #(
  parameter int N_ENTRIES   = 32,
  parameter int N_DATA_BITS = 64,
  parameter int N_META_BITS = 8
);
  localparam int AW = $clog2(N_ENTRIES);

  logic                   req_en;
  logic [AW-1:0]          req_addr;
  logic [N_META_BITS-1:0] req_meta;
  logic                   req_rdy;
  logic [AW-1:0]          ram_addr;
  logic [N_DATA_BITS-1:0] ram_rdata;
  logic                   rsp_valid;
  logic [N_DATA_BITS-1:0] rsp_data;
  logic [N_META_BITS-1:0] rsp_meta;
  logic                   rsp_deq;
  logic                   error;

  modport slave (
    input  req_en, req_addr, req_meta, ram_rdata, rsp_deq,
    output req_rdy, ram_addr, rsp_valid, rsp_data, rsp_meta, error
  );

  modport master (
    output req_en, req_addr, req_meta, ram_rdata, rsp_deq,
    input  req_rdy, ram_addr, rsp_valid, rsp_data, rsp_meta, error
  );
endinterface

// File: rtl/cci_mpf_prim_ram_rd_stream.sv
// Credit-controlled read streamer for one block RAM port: tracks the fixed read
// latency with a valid/meta pipe and buffers returning data in a fall-through FIFO.
module cci_mpf_prim_ram_rd_stream #(
  parameter int N_ENTRIES      = 32,
  parameter int N_DATA_BITS    = 64,
  parameter int N_META_BITS    = 8,
  parameter int N_READ_LATENCY = 1,
  parameter int N_RSP_ENTRIES  = N_READ_LATENCY + 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  cci_mpf_prim_ram_rd_stream_if.slave  rd
);
  localparam int AW = $clog2(N_ENTRIES);
  localparam int L  = N_READ_LATENCY;
  localparam int PW = (N_RSP_ENTRIES > 1) ? $clog2(N_RSP_ENTRIES) : 1;
  localparam int CW = $clog2(N_RSP_ENTRIES + 1);

  logic [CW-1:0]          credits;
  logic                   req_rdy;
  logic                   accept;
  logic [AW-1:0]          ram_addr_q;

  logic [L:1]                  vld_pipe;
  logic [L:1][N_META_BITS-1:0] meta_pipe;

  logic [N_DATA_BITS-1:0] fifo_data [N_RSP_ENTRIES];
  logic [N_META_BITS-1:0] fifo_meta [N_RSP_ENTRIES];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   rsp_valid;
  logic                   fifo_wr, fifo_rd, fifo_push, overflow;
  logic                   err_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N_RSP_ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits alone gate acceptance so nothing in flight can ever overflow the FIFO.
  assign req_rdy     = (credits != '0);
  assign accept      = rd.req_en && req_rdy;
  assign rd.req_rdy  = req_rdy;
  assign rd.ram_addr = accept ? rd.req_addr : ram_addr_q;

  always_ff @(posedge clk) begin
    if (!reset_n)    ram_addr_q <= '0;
    else if (accept) ram_addr_q <= rd.req_addr;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= accept;
      for (int i = 2; i <= L; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    meta_pipe[1] <= rd.req_meta;
    for (int i = 2; i <= L; i++) meta_pipe[i] <= meta_pipe[i-1];
  end

  assign rsp_valid = (count != '0);
  assign fifo_wr   = vld_pipe[L];
  assign fifo_rd   = rd.rsp_deq && rsp_valid;
  assign overflow  = fifo_wr && !fifo_rd && (count == CW'(N_RSP_ENTRIES));
  assign fifo_push = fifo_wr && !overflow;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_rd)   rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(fifo_push) - CW'(fifo_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data[wr_ptr] <= rd.ram_rdata;
      fifo_meta[wr_ptr] <= meta_pipe[L];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) credits <= CW'(N_RSP_ENTRIES);
    else          credits <= credits - CW'(accept) + CW'(fifo_rd);
  end

  // A pop of an empty FIFO is ignored apart from raising the sticky flag.
  always_ff @(posedge clk) begin
    if (!reset_n)                                       err_q <= 1'b0;
    else if ((rd.rsp_deq && !rsp_valid) || overflow)    err_q <= 1'b1;
  end

  assign rd.rsp_valid = rsp_valid;
  assign rd.rsp_data  = fifo_data[rd_ptr];
  assign rd.rsp_meta  = fifo_meta[rd_ptr];
  assign rd.error     = err_q;

  logic [CW-1:0] inflight;
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= L; i++) inflight = inflight + CW'(vld_pipe[i]);
  end

  a_credit_inv: assert property (@(posedge clk) disable iff (!reset_n)
    (32'(credits) + 32'(inflight) + 32'(count)) == N_RSP_ENTRIES);
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !overflow);

  generate
    if (N_ENTRIES < (2 ** AW)) begin : g_addr_chk
      a_addr_range: assert property (@(posedge clk) disable iff (!reset_n)
        accept |-> (32'(rd.req_addr) < N_ENTRIES));
    end
    if (N_READ_LATENCY < 1) begin : g_lat_chk
      $error("N_READ_LATENCY must be >= 1");
    end
  endgenerate
endmodule

// File: tb/tb_cci_mpf_prim_ram_rd_stream.sv
// Directed bench: instance A (latency 1, depth 3) covers reset, single read,
// backpressure, mid-flight reset and protocol error; instance B (latency 2, depth 4) streams.
module tb_cci_mpf_prim_ram_rd_stream;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cci_mpf_prim_ram_rd_stream_if #(.N_ENTRIES(32), .N_DATA_BITS(64), .N_META_BITS(8)) ifa ();
  cci_mpf_prim_ram_rd_stream_if #(.N_ENTRIES(32), .N_DATA_BITS(64), .N_META_BITS(8)) ifb ();

  cci_mpf_prim_ram_rd_stream #(.N_READ_LATENCY(1), .N_RSP_ENTRIES(3)) dut_a (
    .clk(clk), .reset_n(reset_n), .rd(ifa.slave));
  cci_mpf_prim_ram_rd_stream #(.N_READ_LATENCY(2), .N_RSP_ENTRIES(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .rd(ifb.slave));

  function automatic logic [63:0] ram_word(input int a);
    if (a == 5) return 64'h0000_0000_DEAD_BEEF;
    return 64'hCAFE_0000_0000_0000 | 64'(a);
  endfunction

  // RAM models: A has latency 1, B has one extra output register stage.
  logic [63:0] ra_rdata, rb_s1, rb_rdata;
  always @(posedge clk) begin
    ra_rdata <= ram_word(int'(ifa.ram_addr));
    rb_s1    <= ram_word(int'(ifb.ram_addr));
    rb_rdata <= rb_s1;
  end
  assign ifa.ram_rdata = ra_rdata;
  assign ifb.ram_rdata = rb_rdata;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int nrsp, last_cyc;
    bit dropped;
    ifa.req_en = 0; ifa.req_addr = '0; ifa.req_meta = '0; ifa.rsp_deq = 0;
    ifb.req_en = 0; ifb.req_addr = '0; ifb.req_meta = '0; ifb.rsp_deq = 0;
    reset_n = 0;
    repeat (3) step;

    // Reset state
    reset_n = 1; #1;
    chk("rst_rdy_a",   ifa.req_rdy,   1);
    chk("rst_vld_a",   ifa.rsp_valid, 0);
    chk("rst_err_a",   ifa.error,     0);
    chk("rst_addr_a",  ifa.ram_addr,  0);
    chk("rst_rdy_b",   ifb.req_rdy,   1);
    chk("rst_vld_b",   ifb.rsp_valid, 0);

    // Single read: accept in T, response visible in T+2
    step; ifa.req_en = 1; ifa.req_addr = 5'd5; ifa.req_meta = 8'h3C; #1;
    chk("sr_addr", ifa.ram_addr, 5);
    chk("sr_rdy",  ifa.req_rdy,  1);
    step; ifa.req_en = 0; #1;
    chk("sr_hold",  ifa.ram_addr,  5);
    chk("sr_vld1",  ifa.rsp_valid, 0);
    chk("sr_cred1", dut_a.credits, 2);
    step; #1;
    chk("sr_vld2", ifa.rsp_valid, 1);
    chk("sr_data", ifa.rsp_data,  64'h0000_0000_DEAD_BEEF);
    chk("sr_meta", ifa.rsp_meta,  8'h3C);
    ifa.rsp_deq = 1;
    step; ifa.rsp_deq = 0; #1;
    chk("sr_vld3", ifa.rsp_valid, 0);
    chk("sr_cred3", dut_a.credits, 3);

    // Backpressure: 5 offered with no dequeue, only 3 fit
    for (int k = 0; k < 5; k++) begin
      step; ifa.req_en = 1; ifa.req_addr = 5'(10 + k); ifa.req_meta = 8'(8'h80 + k); #1;
      chk("bp_rdy", ifa.req_rdy, (k < 3) ? 1 : 0);
      if (k >= 3) chk("bp_hold", ifa.ram_addr, 12);
    end
    step; ifa.req_en = 0; #1;
    chk("bp_full",  ifa.req_rdy,   0);
    chk("bp_vld",   ifa.rsp_valid, 1);
    chk("bp_d0",    ifa.rsp_data,  ram_word(10));
    chk("bp_m0",    ifa.rsp_meta,  8'h80);
    ifa.rsp_deq = 1;
    for (int j = 1; j < 3; j++) begin
      step; #1;
      chk("bp_rdy_back", ifa.req_rdy, 1);
      chk("bp_d",  ifa.rsp_data, ram_word(10 + j));
      chk("bp_m",  ifa.rsp_meta, 64'(8'h80 + j));
    end
    step; ifa.rsp_deq = 0; #1;
    chk("bp_empty", ifa.rsp_valid, 0);
    chk("bp_cred",  dut_a.credits, 3);

    // Reset with one response buffered, one in the pipe and one being accepted
    step; ifa.req_en = 1; ifa.req_addr = 5'd1; ifa.req_meta = 8'h01;
    step; ifa.req_addr = 5'd2; ifa.req_meta = 8'h02;
    step; ifa.req_addr = 5'd3; ifa.req_meta = 8'h03; reset_n = 0; #1;
    chk("mf_buf",  ifa.rsp_valid, 1);
    chk("mf_cred", dut_a.credits, 1);
    step; reset_n = 1; ifa.req_en = 0; #1;
    chk("mf_vld",  ifa.rsp_valid, 0);
    chk("mf_cred_rst", dut_a.credits, 3);
    chk("mf_rdy",  ifa.req_rdy, 1);
    for (int j = 0; j < 4; j++) begin
      step; #1;
      chk("mf_drop", ifa.rsp_valid, 0);
    end

    // Protocol error: dequeue while empty
    step; ifa.rsp_deq = 1; #1;
    chk("err_pre", ifa.error, 0);
    step; ifa.rsp_deq = 0; #1;
    chk("err_set",  ifa.error,     1);
    chk("err_vld",  ifa.rsp_valid, 0);
    chk("err_cred", dut_a.credits, 3);
    step; step; #1;
    chk("err_sticky", ifa.error, 1);
    step; ifa.req_en = 1; ifa.req_addr = 5'd7; ifa.req_meta = 8'h55;
    step; ifa.req_en = 0;
    step; #1;
    chk("err_rd_vld",  ifa.rsp_valid, 1);
    chk("err_rd_data", ifa.rsp_data,  ram_word(7));
    chk("err_rd_meta", ifa.rsp_meta,  8'h55);
    ifa.rsp_deq = 1;
    step; ifa.rsp_deq = 0; #1;
    chk("err_still", ifa.error, 1);
    step; reset_n = 0;
    step; reset_n = 1; #1;
    chk("err_clr", ifa.error, 0);

    // Streaming on B: cycle 1 is the first accept, so response k shows in cycle k+4
    nrsp = 0; last_cyc = 0; dropped = 0;
    for (int c = 1; c <= 40; c++) begin
      step;
      if (c <= 16) begin
        ifb.req_en = 1; ifb.req_addr = 5'(c - 1); ifb.req_meta = 8'(c - 1);
      end else begin
        ifb.req_en = 0;
      end
      #1;
      if (c <= 16 && !ifb.req_rdy) dropped = 1;
      if (ifb.rsp_valid) begin
        chk("st_data", ifb.rsp_data, ram_word(nrsp));
        chk("st_meta", ifb.rsp_meta, 64'(nrsp));
        nrsp++;
        last_cyc = c;
        ifb.rsp_deq = 1;
      end else begin
        ifb.rsp_deq = 0;
      end
      if (nrsp == 16) break;
    end
    step; ifb.rsp_deq = 0; ifb.req_en = 0; #1;
    chk("st_rdy_drop", 64'(dropped), 0);
    chk("st_count",    64'(nrsp),    16);
    chk("st_last_cyc", 64'(last_cyc), 19);
    chk("st_empty",    ifb.rsp_valid, 0);
    chk("st_cred",     dut_b.credits, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
